spi_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single external SPI memory controller (flash/RAM chip-select decoded by address bit 24). It shares that controller between the instruction-fetch port and the load/store data port, and drives the controller's level-held start / done handshake, including the mandatory start-low gap between transactions. It right-aligns partial reads and runs a watchdog that aborts hung transactions.

---
 rtl/spi_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI memory controller between the fetch and data ports.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data port wins ties.
module spi_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [2:0]  d_num_bytes,
   input  logic        d_is_write,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        mem_start,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_num_bytes,
   output logic        mem_is_write,
   input  logic        mem_done,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   // Handshakes: a requester holds req and its command level until its one-cycle ack and
   // drops req on the edge that samples ack. mem_start is held high for the whole
   // transaction, the controller answers with level mem_done, and mem_start then stays
   // low for at least two cycles so the controller can return to idle.

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  wd_cnt;
   logic        owner_data;
   logic        data_win;
   logic        d_size_bad;
   logic [31:0] rd_aligned;

`ifdef SPI_ARB_ROUND_ROBIN_EN
   logic last_data;

   // Remembers the last grant (illegal-size data requests included); resets to data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_data <= 1'b1;
      end else if (state == S_IDLE && (if_req || d_req)) begin
         last_data <= data_win;
      end
   end

   assign data_win = d_req && (!if_req || !last_data);
`else
   assign data_win = d_req;
`endif

   assign d_size_bad = (d_num_bytes == 3'd0) || (d_num_bytes > 3'd4);
   // Partial reads arrive in the top bytes; move them down to bit 0.
   assign rd_aligned = mem_rdata >> {(3'd4 - mem_num_bytes), 3'b000};
   assign state_dbg  = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         wd_cnt        <= 8'd0;
         owner_data    <= 1'b0;
         mem_start     <= 1'b0;
         mem_addr      <= 32'd0;
         mem_wdata     <= 32'd0;
         mem_num_bytes <= 3'd0;
         mem_is_write  <= 1'b0;
         if_ack        <= 1'b0;
         if_err        <= 1'b0;
         if_rdata      <= 32'd0;
         d_ack         <= 1'b0;
         d_err         <= 1'b0;
         d_rdata       <= 32'd0;
         busy          <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         if_err <= 1'b0;
         d_ack  <= 1'b0;
         d_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (data_win && d_size_bad) begin
                  d_ack   <= 1'b1;
                  d_err   <= 1'b1;
                  d_rdata <= 32'd0;
                  busy    <= 1'b1;
                  state   <= S_RELEASE;
               end else if (data_win) begin
                  mem_addr      <= d_addr;
                  mem_wdata     <= d_wdata;
                  mem_num_bytes <= d_num_bytes;
                  mem_is_write  <= d_is_write;
                  owner_data    <= 1'b1;
                  mem_start     <= 1'b1;
                  wd_cnt        <= 8'd0;
                  busy          <= 1'b1;
                  state         <= S_BUSY;
               end else if (if_req) begin
                  mem_addr      <= if_addr;
                  mem_wdata     <= 32'd0;
                  mem_num_bytes <= 3'd4;
                  mem_is_write  <= 1'b0;
                  owner_data    <= 1'b0;
                  mem_start     <= 1'b1;
                  wd_cnt        <= 8'd0;
                  busy          <= 1'b1;
                  state         <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (mem_done) begin
                  mem_start <= 1'b0;
                  state     <= S_RELEASE;
                  if (owner_data) begin
                     d_ack   <= 1'b1;
                     d_rdata <= rd_aligned;
                  end else begin
                     if_ack   <= 1'b1;
                     if_rdata <= rd_aligned;
                  end
               end else if (wd_cnt == WD_LAST) begin
                  // Watchdog abort: dropping mem_start makes the controller give up.
                  mem_start <= 1'b0;
                  state     <= S_RELEASE;
                  if (owner_data) begin
                     d_ack   <= 1'b1;
                     d_err   <= 1'b1;
                     d_rdata <= 32'd0;
                  end else begin
                     if_ack   <= 1'b1;
                     if_err   <= 1'b1;
                     if_rdata <= 32'd0;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
            end
            S_RELEASE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Testbench for spi_mem_arbiter: directed scenarios plus randomized two-port traffic
// against a transaction-timing model; honours SPI_ARB_ROUND_ROBIN_EN like the design.
`timescale 1ns/1ps
module tb_spi_mem_arbiter;

   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        if_ack, if_err;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic [31:0] d_addr = 32'd0;
   logic [2:0]  d_num_bytes = 3'd0;
   logic        d_is_write = 1'b0;
   logic [31:0] d_wdata = 32'd0;
   logic        d_ack, d_err;
   logic [31:0] d_rdata;
   logic        mem_start;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_num_bytes;
   logic        mem_is_write;
   logic        mem_done = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        busy;
   logic [1:0]  state_dbg;

   int total = 0;
   int bad = 0;

   spi_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_num_bytes(d_num_bytes), .d_is_write(d_is_write),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .mem_start(mem_start), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_num_bytes(mem_num_bytes), .mem_is_write(mem_is_write),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, total=%0d bad=%0d", total, bad);
      $fatal(1, "bench watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory controller responder ----------------
   int          rsp_lat = 0;     // mem_done stays low for rsp_lat start-high cycles; -1 = never
   logic [31:0] rsp_data = 32'd0;
   bit          rsp_rand = 1'b0;
   int          hi_cnt = 0;

   always begin
      @(posedge clk);
      #1;
      if (mem_start) begin
         hi_cnt++;
         if (hi_cnt == 1) begin
            if (rsp_rand) begin
               rsp_lat  = $urandom_range(0, 12);
               rsp_data = $urandom;
            end
            mem_rdata = rsp_data;
         end
         mem_done = (rsp_lat >= 0) && (hi_cnt > rsp_lat);
      end else begin
         hi_cnt   = 0;
         mem_done = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fetch_req(input logic [31:0] a, input bit hold,
                            output logic err, output logic [31:0] rd, output int cyc);
      @(posedge clk);
      #1;
      if_req  = 1'b1;
      if_addr = a;
      cyc = 0;
      err = 1'b0;
      rd  = 32'd0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         cyc++;
         if (if_ack) break;
      end
      if (!if_ack) begin
         total++;
         bad++;
         $display("FAIL fetch_ack_wait: no if_ack within %0d cycles, required 1", cyc);
      end
      err = if_err;
      rd  = if_rdata;
      if (!hold) begin
         @(posedge clk);
         #1;
         if_req = 1'b0;
      end
   endtask

   task automatic data_req(input logic [31:0] a, input logic [2:0] nb, input logic wr,
                           input logic [31:0] wd, input bit hold,
                           output logic err, output logic [31:0] rd, output int cyc);
      @(posedge clk);
      #1;
      d_req       = 1'b1;
      d_addr      = a;
      d_num_bytes = nb;
      d_is_write  = wr;
      d_wdata     = wd;
      cyc = 0;
      err = 1'b0;
      rd  = 32'd0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         cyc++;
         if (d_ack) break;
      end
      if (!d_ack) begin
         total++;
         bad++;
         $display("FAIL data_ack_wait: no d_ack within %0d cycles, required 1", cyc);
      end
      err = d_err;
      rd  = d_rdata;
      if (!hold) begin
         @(posedge clk);
         #1;
         d_req = 1'b0;
      end
   endtask

   // ---------------- model + compare process ----------------
   // Expectations are for the next cycle, derived from the inputs seen this cycle.
   bit          have_exp = 1'b0;
   logic        e_start, e_busy, e_if_ack, e_d_ack, e_if_err, e_d_err, e_wr;
   logic [31:0] e_if_rdata, e_d_rdata, e_addr, e_wdata, word;
   logic [2:0]  e_nb;
   bit          d_known, w_known, free, releasing, o_write, take_data, m_last_data;
   int          owner, hi;

   // Observations used by the directed checks.
   int grant_log[$];
   int gap_log[$];
   int run_len = 0, last_run = 0, low_run = 0, start_rises = 0;
   logic [1:0] exp_q[$];

   always @(negedge clk) begin
      if (have_exp) begin
         chk("mem_start", mem_start, e_start);
         chk("busy", busy, e_busy);
         chk("if_ack", if_ack, e_if_ack);
         chk("d_ack", d_ack, e_d_ack);
         if (e_if_ack) chk("if_err", if_err, e_if_err);
         if (e_d_ack)  chk("d_err", d_err, e_d_err);
         chk("if_rdata", if_rdata, e_if_rdata);
         if (d_known) chk("d_rdata", d_rdata, e_d_rdata);
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_num_bytes", mem_num_bytes, e_nb);
         chk("mem_is_write", mem_is_write, e_wr);
         if (w_known) chk("mem_wdata", mem_wdata, e_wdata);
         chk("one_ack", if_ack & d_ack, 1'b0);
      end

      if (if_ack) grant_log.push_back(1);
      if (d_ack)  grant_log.push_back(2);
      if (mem_start) begin
         if (run_len == 0) begin
            start_rises++;
            gap_log.push_back(low_run);
         end
         run_len++;
         low_run = 0;
      end else begin
         if (run_len > 0) last_run = run_len;
         run_len = 0;
         low_run++;
      end

      e_if_ack = 1'b0;
      e_d_ack  = 1'b0;
      e_if_err = 1'b0;
      e_d_err  = 1'b0;
      if (!rst_n) begin
         e_start = 0; e_busy = 0; e_if_rdata = 0; e_d_rdata = 0;
         e_addr = 0; e_wdata = 0; e_nb = 0; e_wr = 0;
         d_known = 1; w_known = 1; free = 1; releasing = 0; owner = 0; hi = 0;
         m_last_data = 1;
         have_exp = 1'b1;
      end else if (releasing) begin
         releasing = 0;
         free      = 1;
         e_busy    = 0;
      end else if (free) begin
         if (if_req || d_req) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
            take_data = d_req && (!if_req || !m_last_data);
`else
            take_data = d_req;
`endif
            m_last_data = take_data;
            free   = 0;
            e_busy = 1;
            if (take_data && (d_num_bytes == 3'd0 || d_num_bytes > 3'd4)) begin
               e_d_ack = 1; e_d_err = 1; e_d_rdata = 0; d_known = 1;
               releasing = 1;
            end else if (take_data) begin
               e_start = 1; owner = 2; hi = 0;
               e_addr = d_addr; e_nb = d_num_bytes; e_wr = d_is_write;
               e_wdata = d_wdata; w_known = d_is_write; o_write = d_is_write;
            end else begin
               e_start = 1; owner = 1; hi = 0;
               e_addr = if_addr; e_nb = 3'd4; e_wr = 0; w_known = 0; o_write = 0;
            end
         end
      end else if (owner != 0) begin
         hi++;
         if (mem_done) begin
            word = mem_rdata >> (32 - 8 * int'(e_nb));
            if (owner == 1) begin
               e_if_ack = 1; e_if_rdata = word;
            end else begin
               e_d_ack = 1; e_d_rdata = word; d_known = !o_write;
            end
            e_start = 0; releasing = 1; owner = 0;
         end else if (hi == TMO) begin
            if (owner == 1) begin
               e_if_ack = 1; e_if_err = 1; e_if_rdata = 0;
            end else begin
               e_d_ack = 1; e_d_err = 1; e_d_rdata = 0; d_known = 1;
            end
            e_start = 0; releasing = 1; owner = 0;
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic        err;
      logic [31:0] rd;
      int          cyc;
      int          rises0;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mem_start", mem_start, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
      chk("rst_errs", {30'd0, if_err, d_err}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);

      // Fetch with a 60-cycle controller latency.
      rsp_rand = 0; rsp_lat = 60; rsp_data = 32'h1300_0000;
      fetch_req(32'h0000_0010, 0, err, rd, cyc);
      chk("fetch_err", err, 1'b0);
      chk("fetch_rdata", rd, 32'h1300_0000);
      chk("fetch_start_len", last_run, 61);
      chk("fetch_mem_addr", mem_addr, 32'h0000_0010);

      // Partial loads: top bytes shifted down to bit 0.
      rsp_lat = 2; rsp_data = 32'hAB00_0000;
      data_req(32'h0100_0003, 3'd1, 1'b0, 32'd0, 0, err, rd, cyc);
      chk("ld1_nb", mem_num_bytes, 3'd1);
      chk("ld1_rdata", rd, 32'h0000_00AB);
      rsp_data = 32'hCDAB_0000;
      data_req(32'h0100_0004, 3'd2, 1'b0, 32'd0, 0, err, rd, cyc);
      chk("ld2_nb", mem_num_bytes, 3'd2);
      chk("ld2_rdata", rd, 32'h0000_CDAB);

      // Contested grants, both ports re-raising immediately after each ack.
      rsp_lat = 3; rsp_data = 32'h1234_5678;
      grant_log.delete();
      gap_log.delete();
`ifdef SPI_ARB_ROUND_ROBIN_EN
      exp_q = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
`else
      exp_q = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
`endif
      fork
         begin
            logic e1; logic [31:0] r1; int c1;
            for (int i = 0; i < 3; i++) fetch_req(32'h40 + 32'(i * 4), i < 2, e1, r1, c1);
         end
         begin
            logic e2; logic [31:0] r2; int c2;
            for (int i = 0; i < 3; i++) data_req(32'h80 + 32'(i * 4), 3'd4, 1'b0, 32'd0, i < 2, e2, r2, c2);
         end
      join
      chk("contest_count", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("contest_grant", grant_log[i], exp_q[i]);
      for (int i = 1; i < 6 && i < gap_log.size(); i++) chk("contest_gap", gap_log[i], 2);

      // Store that the controller never finishes: watchdog abort.
      rsp_lat = -1;
      data_req(32'h0000_0100, 3'd4, 1'b1, 32'hDEAD_BEEF, 0, err, rd, cyc);
      chk("tmo_err", err, 1'b1);
      chk("tmo_rdata", rd, 32'd0);
      chk("tmo_start_len", last_run, TMO);

      // Illegal sizes: immediate error ack, no controller access.
      rises0 = start_rises;
      data_req(32'h0000_0200, 3'd5, 1'b0, 32'd0, 0, err, rd, cyc);
      chk("bad5_err", err, 1'b1);
      chk("bad5_latency", cyc, 2);
      chk("bad5_rdata", rd, 32'd0);
      data_req(32'h0000_0200, 3'd0, 1'b0, 32'd0, 0, err, rd, cyc);
      chk("bad0_err", err, 1'b1);
      chk("bad0_latency", cyc, 2);
      chk("bad_no_start", start_rises, rises0);

      // Reset in the 10th BUSY cycle.
      rsp_lat = 100;
      @(posedge clk);
      #1;
      if_req = 1'b1; if_addr = 32'h0000_0020;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_start) break;
      end
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0; if_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_start", mem_start, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_ack", {31'd0, if_ack}, 32'd0);
      rsp_lat = 1; rsp_data = 32'h0000_0013;
      fetch_req(32'h0000_0024, 0, err, rd, cyc);
      chk("after_rst_err", err, 1'b0);
      chk("after_rst_rdata", rd, 32'h0000_0013);

      // Randomized traffic on both ports.
      rsp_rand = 1;
      fork
         begin
            logic e1; logic [31:0] r1; int c1;
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 5)) @(posedge clk);
               fetch_req($urandom, 0, e1, r1, c1);
            end
         end
         begin
            logic e2; logic [31:0] r2; int c2; logic [2:0] nb;
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 5)) @(posedge clk);
               nb = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 8) % 8) : 3'($urandom_range(1, 4));
               data_req($urandom, nb, 1'($urandom_range(0, 1)), $urandom, 0, e2, r2, c2);
            end
         end
      join
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
